rggen_native_bus_adapter: RTL and testbench
===========================================

RGGEN_NATIVE_BUS_ADAPTER -- requirements
Module: rggen_native_bus_adapter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8: width of command address and local register address.
REQ-002 SHALL have parameter BUS_WIDTH, default 32: data width; strobe width is BUS_WIDTH/8.
REQ-003 SHALL have parameter REGISTERS, default 1: number of downstream registers served.
REQ-004 SHALL have parameter BASE_ADDRESS (ADDRESS_WIDTH bits), default 0: first byte of the register block.
REQ-005 SHALL have parameter BYTE_SIZE, default 256: block span in bytes.
REQ-006 SHALL have parameter ERROR_STATUS, default 0: 1 selects decode-error status for unmapped accesses, 0 selects OKAY.
REQ-007 SHALL have parameter DEFAULT_READ_DATA (BUS_WIDTH bits), default 0: read data returned for unmapped accesses.
REQ-008 SHALL have parameter TIMEOUT, default 0: cycles to wait for a register response; 0 disables the watchdog.
REQ-009 SHALL have port i_clk, input, 1 bit: single clock; all state on its rising edge.
REQ-010 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-011 SHALL have ports i_cmd_valid (input, 1), o_cmd_ready (output, 1): command handshake.
REQ-012 SHALL have command payload inputs: i_cmd_address (ADDRESS_WIDTH), i_cmd_write (1), i_cmd_write_data (BUS_WIDTH), i_cmd_strobe (BUS_WIDTH/8).
REQ-013 SHALL have ports o_rsp_valid (output, 1), i_rsp_ready (input, 1): response handshake.
REQ-014 SHALL have response outputs: o_rsp_status (2; 00 OKAY, 10 slave error, 11 decode error), o_rsp_read_data (BUS_WIDTH).
REQ-015 SHALL have register-side outputs broadcast to all registers: o_reg_valid (1), o_reg_write (1), o_reg_address (ADDRESS_WIDTH), o_reg_write_data (BUS_WIDTH), o_reg_strobe (BUS_WIDTH/8).
REQ-016 SHALL have register-side inputs per register: i_reg_active (REGISTERS), i_reg_ready (REGISTERS), i_reg_status (2*REGISTERS), i_reg_read_data (BUS_WIDTH*REGISTERS).

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, RESPOND.
REQ-018 o_cmd_ready SHALL be 1 only in IDLE; command accepted when i_cmd_valid && o_cmd_ready.
REQ-019 On accept, SHALL latch all payload fields, compute in_range = (addr >= BASE_ADDRESS) && (addr - BASE_ADDRESS < BYTE_SIZE), and go to BUSY if in_range, else to RESPOND.
REQ-020 In BUSY, o_reg_valid SHALL be 1, starting the cycle after accept; o_reg_address = latched address - BASE_ADDRESS, truncated to ADDRESS_WIDTH; other o_reg_* outputs = latched payload.
REQ-021 Out of BUSY, o_reg_valid SHALL be 0; other o_reg_* outputs hold their last values.
REQ-022 In BUSY, if any i_reg_active bit is 1 and the same register's i_reg_ready is 1: SHALL capture that register's status and read data (OR-reduced across active registers) and go to RESPOND next cycle.
REQ-023 In BUSY, if no i_reg_active bit is 1: SHALL go to RESPOND with status 11 (ERROR_STATUS=1) or 00 (ERROR_STATUS=0), read data DEFAULT_READ_DATA.
REQ-024 An out-of-range command SHALL produce the same response as REQ-023 and SHALL never assert o_reg_valid.
REQ-025 If TIMEOUT>0: watchdog SHALL count BUSY cycles from 1; if it reaches TIMEOUT without ready, SHALL go to RESPOND with status 10 and read data 0. Ready in that same cycle SHALL take priority.
REQ-026 In RESPOND, o_rsp_valid SHALL be 1 with stable status/data until i_rsp_ready; then SHALL go to IDLE, so the next command can be accepted the cycle after.
REQ-027 Minimum latency SHALL be: accept at cycle 0, o_reg_valid at cycle 1, ready at cycle 1, o_rsp_valid at cycle 2. Throughput is at most one command per 3 cycles.
REQ-028 Write responses SHALL carry read data 0.

Reset
REQ-029 While i_rst=1 (asynchronous): state=IDLE; o_cmd_ready=0; o_rsp_valid=0; o_reg_valid=0; o_rsp_status=00; all data/address/strobe outputs=0; watchdog=0.
REQ-030 Reset during BUSY or RESPOND SHALL abort the transfer with no response. o_cmd_ready SHALL be 1 the first cycle after release.

Verification
REQ-031 Write 0x10, data 0xDEADBEEF, strobe 0xF, register 4 active and ready in 1 cycle -> o_reg_valid for exactly 1 cycle, o_reg_address=0x10, o_rsp_valid at cycle 2, status 00, data 0.
REQ-032 Read 0x04, register 1 ready after 3 BUSY cycles with data 0x12345678 -> response 0x12345678, status 00; o_cmd_ready low throughout.
REQ-033 BASE_ADDRESS=0x40, BYTE_SIZE=0x20, read 0x80, ERROR_STATUS=1 -> no o_reg_valid, status 11, data DEFAULT_READ_DATA.
REQ-034 TIMEOUT=4, register active but never ready -> status 10 after 4 BUSY cycles. Repeat with ready on the 4th cycle -> register status returned.
REQ-035 Response held with i_rsp_ready=0 for 5 cycles -> outputs stable, o_cmd_ready=0, a new i_cmd_valid is not accepted until 1 cycle after the response handshake.
REQ-036 Assert i_rst mid-BUSY -> all outputs at reset values immediately; no response after release; next command is handled normally.

Source files
------------

// File: rtl/rggen_native_bus_adapter.sv
// Native command/response bus to RgGen register-block adapter.
// Decodes the block range, broadcasts the access and relays one response.
module rggen_native_bus_adapter #(
  parameter int                         ADDRESS_WIDTH     = 8,
  parameter int                         BUS_WIDTH         = 32,
  parameter int                         REGISTERS         = 1,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS      = '0,
  parameter int                         BYTE_SIZE         = 256,
  parameter bit                         ERROR_STATUS      = 1'b0,
  parameter logic [BUS_WIDTH-1:0]       DEFAULT_READ_DATA = '0,
  parameter int                         TIMEOUT           = 0,
  localparam int                        SW                = BUS_WIDTH / 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0]       i_cmd_address,
  input  logic                           i_cmd_write,
  input  logic [BUS_WIDTH-1:0]           i_cmd_write_data,
  input  logic [SW-1:0]                  i_cmd_strobe,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [1:0]                     o_rsp_status,
  output logic [BUS_WIDTH-1:0]           o_rsp_read_data,
  output logic                           o_reg_valid,
  output logic                           o_reg_write,
  output logic [ADDRESS_WIDTH-1:0]       o_reg_address,
  output logic [BUS_WIDTH-1:0]           o_reg_write_data,
  output logic [SW-1:0]                  o_reg_strobe,
  input  logic [REGISTERS-1:0]           i_reg_active,
  input  logic [REGISTERS-1:0]           i_reg_ready,
  input  logic [2*REGISTERS-1:0]         i_reg_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_reg_read_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  logic [1:0]               r_state;
  logic                     r_write;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [BUS_WIDTH-1:0]     r_wdata;
  logic [SW-1:0]            r_strobe;
  logic [1:0]               r_status;
  logic [BUS_WIDTH-1:0]     r_rdata;
  logic [31:0]              r_wdog;

  logic                     w_accept;
  logic [ADDRESS_WIDTH-1:0] w_offset;
  logic                     w_in_range;
  logic                     w_active;
  logic                     w_hit;
  logic                     w_timeout;
  logic [31:0]              w_wdog_next;
  logic [1:0]               w_sel_status;
  logic [BUS_WIDTH-1:0]     w_sel_data;
  logic [1:0]               w_err_status;

  assign o_cmd_ready      = (r_state == IDLE) & ~i_rst;
  assign o_reg_valid      = (r_state == BUSY);
  assign o_rsp_valid      = (r_state == RESPOND);
  assign o_reg_write      = r_write;
  assign o_reg_address    = r_address;
  assign o_reg_write_data = r_wdata;
  assign o_reg_strobe     = r_strobe;
  assign o_rsp_status     = r_status;
  assign o_rsp_read_data  = r_rdata;

  assign w_accept     = i_cmd_valid & o_cmd_ready;
  assign w_offset     = i_cmd_address - BASE_ADDRESS;
  assign w_in_range   = (i_cmd_address >= BASE_ADDRESS) &&
                        (64'(w_offset) < 64'(BYTE_SIZE));
  assign w_active     = |i_reg_active;
  assign w_hit        = |(i_reg_active & i_reg_ready);
  assign w_wdog_next  = r_wdog + 32'd1;
  assign w_timeout    = (TIMEOUT > 0) && (w_wdog_next == 32'(TIMEOUT));
  assign w_err_status = ERROR_STATUS ? 2'b11 : 2'b00;

  // Only the decoded register should be active; OR keeps the mux small.
  always_comb begin
    w_sel_status = '0;
    w_sel_data   = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (i_reg_active[i]) begin
        w_sel_status = w_sel_status | i_reg_status[2*i+:2];
        w_sel_data   = w_sel_data | i_reg_read_data[BUS_WIDTH*i+:BUS_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_write   <= 1'b0;
      r_address <= '0;
      r_wdata   <= '0;
      r_strobe  <= '0;
      r_status  <= 2'b00;
      r_rdata   <= '0;
      r_wdog    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write   <= i_cmd_write;
            r_address <= w_offset;
            r_wdata   <= i_cmd_write_data;
            r_strobe  <= i_cmd_strobe;
            r_wdog    <= '0;
            if (w_in_range) begin
              r_state <= BUSY;
            end else begin
              r_state  <= RESPOND;
              r_status <= w_err_status;
              r_rdata  <= i_cmd_write ? '0 : DEFAULT_READ_DATA;
            end
          end
        end
        BUSY: begin
          r_wdog <= w_wdog_next;
          // Ready wins over the watchdog in the same cycle.
          if (w_hit) begin
            r_state  <= RESPOND;
            r_status <= w_sel_status;
            r_rdata  <= r_write ? '0 : w_sel_data;
          end else if (!w_active) begin
            r_state  <= RESPOND;
            r_status <= w_err_status;
            r_rdata  <= r_write ? '0 : DEFAULT_READ_DATA;
          end else if (w_timeout) begin
            r_state  <= RESPOND;
            r_status <= 2'b10;
            r_rdata  <= '0;
          end
        end
        RESPOND: begin
          if (i_rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_native_bus_adapter.sv
// Directed bench with a response scoreboard for rggen_native_bus_adapter.
// Block at 0x40..0x5F, four registers, decode errors on, 4-cycle watchdog.
module tb_rggen_native_bus_adapter;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int NR = 4;
  localparam logic [31:0] DRD = 32'hBADC0DE5;

  logic           clk = 1'b0;
  logic           i_rst;
  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic [AW-1:0]  i_cmd_address;
  logic           i_cmd_write;
  logic [BW-1:0]  i_cmd_write_data;
  logic [3:0]     i_cmd_strobe;
  logic           o_rsp_valid;
  logic           i_rsp_ready;
  logic [1:0]     o_rsp_status;
  logic [BW-1:0]  o_rsp_read_data;
  logic           o_reg_valid;
  logic           o_reg_write;
  logic [AW-1:0]  o_reg_address;
  logic [BW-1:0]  o_reg_write_data;
  logic [3:0]     o_reg_strobe;
  logic [NR-1:0]  act;
  logic [NR-1:0]  i_reg_ready;
  logic [2*NR-1:0] st_vec;
  logic [BW*NR-1:0] rd_vec;

  int             rdy_at;
  int             tb_busy;
  int             n_vec = 0;
  int             n_err = 0;
  logic [33:0]    sb[$];

  always #5 clk = ~clk;

  rggen_native_bus_adapter #(
    .ADDRESS_WIDTH     (AW),
    .BUS_WIDTH         (BW),
    .REGISTERS         (NR),
    .BASE_ADDRESS      (8'h40),
    .BYTE_SIZE         (32),
    .ERROR_STATUS      (1'b1),
    .DEFAULT_READ_DATA (DRD),
    .TIMEOUT           (4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .i_cmd_address    (i_cmd_address),
    .i_cmd_write      (i_cmd_write),
    .i_cmd_write_data (i_cmd_write_data),
    .i_cmd_strobe     (i_cmd_strobe),
    .o_rsp_valid      (o_rsp_valid),
    .i_rsp_ready      (i_rsp_ready),
    .o_rsp_status     (o_rsp_status),
    .o_rsp_read_data  (o_rsp_read_data),
    .o_reg_valid      (o_reg_valid),
    .o_reg_write      (o_reg_write),
    .o_reg_address    (o_reg_address),
    .o_reg_write_data (o_reg_write_data),
    .o_reg_strobe     (o_reg_strobe),
    .i_reg_active     (act),
    .i_reg_ready      (i_reg_ready),
    .i_reg_status     (st_vec),
    .i_reg_read_data  (rd_vec)
  );

  // Register model: ready on the rdy_at-th BUSY cycle, never when 0.
  always @(posedge clk or posedge i_rst) begin
    if (i_rst) tb_busy <= 0;
    else tb_busy <= o_reg_valid ? tb_busy + 1 : 0;
  end
  assign i_reg_ready = (o_reg_valid && rdy_at != 0 && tb_busy + 1 == rdy_at)
                       ? act : '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [7:0] a,
                      input logic w, input logic [31:0] wd,
                      input logic [3:0] stb, input logic [1:0] es,
                      input logic [31:0] ed, input int exp_lat,
                      input int exp_busy, input int hold);
    int g, lat, nb;
    logic sr;
    logic [33:0] e;
    logic [AW-1:0] ra;
    logic [BW-1:0] rw;
    logic [3:0] rs;
    logic rwr;
    @(negedge clk);
    i_cmd_address = a; i_cmd_write = w;
    i_cmd_write_data = wd; i_cmd_strobe = stb;
    i_cmd_valid = 1'b1;
    g = 0;
    while (!o_cmd_ready && g < 20) begin @(negedge clk); g++; end
    chk({tag, "_accept"}, 64'(o_cmd_ready), 64'd1);
    if (!o_cmd_ready) begin i_cmd_valid = 1'b0; return; end
    sb.push_back({es, ed});
    @(posedge clk); #1 i_cmd_valid = 1'b0;
    lat = 0; nb = 0; sr = 1'b0;
    ra = '0; rw = '0; rs = '0; rwr = 1'b0;
    while (lat < 30) begin
      @(negedge clk); lat++;
      if (o_rsp_valid) break;
      if (o_cmd_ready) sr = 1'b1;
      if (o_reg_valid) begin
        nb++;
        if (nb == 1) begin
          ra = o_reg_address; rw = o_reg_write_data;
          rs = o_reg_strobe; rwr = o_reg_write;
        end
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    chk({tag, "_cmd_ready_low"}, 64'(sr), 64'd0);
    if (exp_busy > 0)
      chk({tag, "_reg_fields"}, {19'd0, rwr, ra, rw, rs},
          {19'd0, w, a - 8'h40, wd, stb});
    if (!o_rsp_valid) return;
    e = sb.pop_front();
    chk({tag, "_response"}, 64'({o_rsp_status, o_rsp_read_data}), 64'(e));
    for (int h = 0; h < hold; h++) begin
      i_cmd_address = 8'h48; i_cmd_write = 1'b0;
      i_cmd_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_hold"},
          64'({o_rsp_valid, o_cmd_ready, o_reg_valid,
               o_rsp_status, o_rsp_read_data}),
          64'({3'b100, e}));
    end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1 i_rsp_ready = 1'b0; i_cmd_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_after_hs"}, 64'({o_rsp_valid, o_cmd_ready, o_reg_valid}),
        64'(3'b010));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    logic seen;
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_rsp_ready = 1'b0;
    i_cmd_address = '0; i_cmd_write = 1'b0;
    i_cmd_write_data = '0; i_cmd_strobe = '0;
    act = '0; rdy_at = 0; st_vec = '0; rd_vec = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'({o_cmd_ready, o_rsp_valid, o_reg_valid,
        o_reg_write, o_rsp_status, o_rsp_read_data}), 64'd0);
    chk("reset_reg", 64'({o_reg_address, o_reg_write_data, o_reg_strobe}),
        64'd0);
    i_rst = 1'b0;
    @(negedge clk);
    chk("release_ready", 64'(o_cmd_ready), 64'd1);

    act = 4'b1000; rdy_at = 1;
    send("wr_min", 8'h50, 1'b1, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 2, 1, 0);

    act = 4'b0010; rdy_at = 3;
    rd_vec[BW*1+:BW] = 32'h12345678;
    send("rd_wait3", 8'h44, 1'b0, 32'h0, 4'h0, 2'b00, 32'h12345678, 4, 3, 0);

    act = 4'b0001; rdy_at = 1;
    send("rd_oor_80", 8'h80, 1'b0, 32'h0, 4'h0, 2'b11, DRD, 1, 0, 0);
    send("rd_oor_3f", 8'h3F, 1'b0, 32'h0, 4'h0, 2'b11, DRD, 1, 0, 0);
    send("rd_oor_60", 8'h60, 1'b0, 32'h0, 4'h0, 2'b11, DRD, 1, 0, 0);

    act = 4'b0001; rdy_at = 0;
    send("timeout", 8'h40, 1'b0, 32'h0, 4'h0, 2'b10, 32'h0, 5, 4, 0);

    act = 4'b0001; rdy_at = 4;
    rd_vec[BW*0+:BW] = 32'hA5A55A5A;
    send("ready_at_to", 8'h40, 1'b0, 32'h0, 4'h0, 2'b00, 32'hA5A55A5A,
         5, 4, 0);

    act = 4'b0000; rdy_at = 1;
    send("no_active", 8'h5F, 1'b0, 32'h0, 4'h0, 2'b11, DRD, 2, 1, 0);

    act = 4'b0011; rdy_at = 2;
    st_vec = 8'b0000_1000;
    rd_vec[BW*0+:BW] = 32'h0F0F0000;
    rd_vec[BW*1+:BW] = 32'h000000F0;
    send("or_reduce", 8'h5C, 1'b0, 32'h0, 4'h0, 2'b10, 32'h0F0F00F0,
         3, 2, 0);

    act = 4'b0100; rdy_at = 1; st_vec = '0;
    rd_vec[BW*2+:BW] = 32'hFFFFFFFF;
    send("wr_zero_rd", 8'h48, 1'b1, 32'h01020304, 4'h5, 2'b00, 32'h0,
         2, 1, 0);

    act = 4'b0001; rdy_at = 1;
    rd_vec[BW*0+:BW] = 32'h11112222;
    send("rsp_hold", 8'h4C, 1'b0, 32'h0, 4'h0, 2'b00, 32'h11112222,
         2, 1, 5);

    act = 4'b0001; rdy_at = 0;
    @(negedge clk);
    i_cmd_address = 8'h54; i_cmd_write = 1'b1;
    i_cmd_write_data = 32'hCAFEF00D; i_cmd_strobe = 4'hC;
    i_cmd_valid = 1'b1;
    @(posedge clk); #1 i_cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", 64'(o_reg_valid), 64'd1);
    #1 i_rst = 1'b1;
    #1;
    chk("rst_async_ctrl", 64'({o_cmd_ready, o_rsp_valid, o_reg_valid,
        o_reg_write, o_rsp_status, o_rsp_read_data}), 64'd0);
    chk("rst_async_reg", 64'({o_reg_address, o_reg_write_data,
        o_reg_strobe}), 64'd0);
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 64'(o_cmd_ready), 64'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_rsp_valid || o_reg_valid) seen = 1'b1;
    end
    chk("rst_no_response", 64'(seen), 64'd0);

    act = 4'b0100; rdy_at = 1;
    st_vec = 8'b0010_0000;
    rd_vec[BW*2+:BW] = 32'h76543210;
    send("post_reset", 8'h58, 1'b0, 32'h0, 4'h0, 2'b10, 32'h76543210,
         2, 1, 0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
